// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// State encoding: IDLE=00, SHIFT=01, DONE=10; 11 recovers to IDLE.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bit counter must be able to hold WIDTH itself
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d;
    logic             bout;
    logic             accept;
    logic             last;

    full_subtractor_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // Accept a request only when idle or finishing; flag the final bit
    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last ? DONE : SHIFT;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Operand/result shifting, borrow chain and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            res        <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {d, res[WIDTH-1:1]};
            bin  <= bout;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff       <= {d, res[WIDTH-1:1]};
                borrow_out <= bout;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Signed overflow: operand signs differ and result sign differs from a
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (a_msb != b_msb) && (d != a_msb);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a
// reference model built from plain integer arithmetic.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int total = 0;
    int bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_diff(input int x, input int y);
        int r;
        r = (x - y + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic m_borrow(input int x, input int y);
        return x < y;
    endfunction

    function automatic logic m_ovf(input int x, input int y);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        int sx, sy, s;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        s  = sx - sy;
        return (s < -128) || (s > 127);
`else
        return 1'b0;
`endif
    endfunction

    // Wait from the first busy cycle until done; returns cycles waited
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int x, input int y);
        check({tag, "_diff"}, diff, m_diff(x, y));
        check({tag, "_brw"}, borrow_out, m_borrow(x, y));
        check({tag, "_ovf"}, ovf, m_ovf(x, y));
    endtask

    // Full operation: issue, check latency and result, check done drops
    task automatic op(input string tag, input int x, input int y);
        int n;
        @(negedge clk);
        start = 1'b1;
        a = x[W-1:0];
        b = y[W-1:0];
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(n);
        check({tag, "_lat"}, n, W);
        check({tag, "_bsy0"}, busy, 1'b0);
        check_result(tag, x, y);
        @(negedge clk);
        check({tag, "_dn0"}, done, 1'b0);
        check({tag, "_hold"}, diff, m_diff(x, y));
    endtask

    initial begin
        int n, pulses, x, y;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 0);
        check("rst_brw", borrow_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        op("t200_55", 200, 55);
        check("t200_55_k", diff, 8'h91);
        op("t5_10", 5, 10);
        check("t5_10_k", diff, 8'hFB);
        op("t0_0", 0, 0);
        op("tff_ff", 255, 255);
        op("t80_01", 128, 1);
        check("t80_01_k", diff, 8'h7F);

        // start during SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) check("ign_diff", diff, 8'd6);
            end
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);

        // reset in busy cycle 4
        @(negedge clk);
        start = 1'b1; a = 8'd50; b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_busy0", busy, 1'b0);
        check("rr_diff0", diff, 0);
        check("rr_brw0", borrow_out, 1'b0);
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("rr_quiet", pulses, 0);
        op("t7_7", 7, 7);

        // back to back: start held through DONE
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("bb1_lat", n, W);
        check_result("bb1", 100, 1);
        start = 1'b1; a = 8'd20; b = 8'd30;
        @(negedge clk);
        start = 1'b0;
        check("bb2_busy", busy, 1'b1);
        check("bb2_done0", done, 1'b0);
        wait_done(n);
        check("bb2_lat", n, W);
        check_result("bb2", 20, 30);
        check("bb2_k", diff, 8'hF6);

        // randomized operations
        for (int i = 0; i < 25; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            op("rnd", x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, through a single-bit full-subtractor cell and a registered borrow. It is the subtraction counterpart of the team's adder primitives and serves area-constrained datapaths that can tolerate WIDTH-cycle latency. It uses a start/busy/done handshake so a sequencer can issue operations back to back.

## Interface
- `WIDTH`, 8: operand and result width in bits; legal range 2..64.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `a`  input  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  input  WIDTH  subtrahend; captured on the accepted `start` edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  result `a - b` mod 2^WIDTH; held until the next accepted start.
- `borrow_out`  output  1  final borrow; 1 iff unsigned `a < b`.
- `ovf`  output  1  signed overflow; see Configuration.

## Operation
- States: IDLE (00), SHIFT (01), DONE (10). Encoding 11 is illegal and recovers to IDLE on the next edge.
- IDLE/DONE, `start`=1:
  - Load `a` and `b` into shift registers.
  - Clear the borrow FF and bit counter; clear `diff`, `borrow_out`, `ovf`.
  - Go to SHIFT.
- IDLE, `start`=0: remain in IDLE.
- DONE, `start`=0: go to IDLE.
- SHIFT, each edge:
  - `d = a0 ^ b0 ^ bin`; `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`.
  - Shift `d` into the result register from the MSB side; shift the operand registers right.
  - `bin <= bout`; increment the counter.
- SHIFT, edge that processes bit WIDTH-1:
  - Present the result on `diff`; set `borrow_out` to the final `bout`.
  - Go to DONE.
- `start` during SHIFT is ignored. Operands are not re-captured, and there is no queueing.
- `rst` mid-operation:
  - The next edge returns to IDLE and zeroes all state.
  - The partial result is discarded; no `done` pulse.
- Arithmetic is modulo 2^WIDTH. `borrow_out` is the unsigned underflow indicator.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `ovf`=0; state IDLE.
- Start accepted at edge k:
  - `busy`=1 for cycles k+1 .. k+WIDTH.
  - `done`=1 in the cycle after edge k+WIDTH only.
  - Latency from accepted start to `done` is WIDTH cycles.
- Back to back: `start` held high in the DONE cycle is accepted, so `busy` rises the very next cycle. Throughput is one op per WIDTH+1 cycles.
- `diff`, `borrow_out` and `ovf` are stable from `done` until the edge after the next accepted start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_SUBTRACTOR_OVF_EN` defined:
  - Capture the MSBs of `a` and `b` at start.
  - `ovf` = (a_msb != b_msb) && (diff_msb != a_msb), registered with `diff`.
- Undefined: `ovf` is tied to 0 and no overflow logic is built. The port is present either way.

## Structure
- Package `serial_subtractor_pkg`:
  - State typedef and encodings (IDLE, SHIFT, DONE).
  - Counter-width constant `$clog2(WIDTH+1)`.
- Sub-module `full_subtractor_bit`: purely combinational one-bit cell with inputs `a`, `b`, `bin` and outputs `d`, `bout`; instantiated once.

## Test plan
- WIDTH=8, a=200, b=55 -> `done` WIDTH cycles after start; `diff`=8'h91, `borrow_out`=0.
- a=5, b=10 -> `diff`=8'hFB, `borrow_out`=1; a=0, b=0 and a=8'hFF, b=8'hFF -> `diff`=0, `borrow_out`=0.
- Start a=9, b=3, then pulse `start` with a=1, b=2 at busy cycle 3 -> `diff`=6; exactly one `done` pulse.
- Assert `rst` during busy cycle 4 -> next cycle all outputs 0 and state IDLE; a new start with a=7, b=7 -> `diff`=0 after WIDTH cycles.
- `start` held high across DONE with a new pair 20-30 -> second `busy` begins the cycle after `done`; `diff`=8'hF6, `borrow_out`=1.
- a=8'h80, b=8'h01 -> `diff`=8'h7F, `borrow_out`=0; `ovf`=1 with the macro defined, 0 without.
